// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: direct-mapped instruction buffer answering hits in the same
// cycle, with misses fetched over a single-outstanding req/ack instruction bus.
module inst_fetch_resp #(
    parameter int unsigned IDX_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic        inv_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e state, state_next;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic [31:0]      bus_addr_next;
    logic [IDX_W-1:0] pc_idx, fill_idx;
    logic [TAG_W-1:0] pc_tag, fill_tag;
    logic             hit, miss, fill;
    logic             unused_pc;

    assign pc_idx    = pc_i[IDX_W+1:2];
    assign pc_tag    = pc_i[31:IDX_W+2];
    assign fill_idx  = bus_addr_o[IDX_W+1:2];
    assign fill_tag  = bus_addr_o[31:IDX_W+2];
    assign unused_pc = ^pc_i[1:0];

    assign hit  = ce_i && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign miss = ce_i && !hit;

    // The request line is simply the BUSY state, so it is registered and drops on reset.
    assign bus_req_o = (state == StBusy);

    always_comb begin
        state_next    = state;
        bus_addr_next = bus_addr_o;
        fill          = 1'b0;
        stallreq_o    = 1'b0;
        inst_o        = '0;
        unique case (state)
            StIdle: begin
                if (miss) begin
                    stallreq_o    = 1'b1;
                    state_next    = StBusy;
                    bus_addr_next = {pc_i[31:2], 2'b00};
                end else if (hit) begin
                    inst_o = data_mem[pc_idx];
                end
            end
            StBusy: begin
                // PC is frozen on the missing address; stall even if it now looks like a hit.
                stallreq_o = ce_i;
                if (bus_ack_i) begin
                    fill       = 1'b1;
                    state_next = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            bus_addr_o <= '0;
            valid      <= '0;
        end else begin
            state      <= state_next;
            bus_addr_o <= bus_addr_next;
            if (inv_i) begin
                valid <= '0;
            end else if (fill) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus_rdata_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed scenarios plus randomized traffic checked against a
// word-address keyed buffer model.
module tb_inst_fetch_resp;

    localparam int unsigned IDX_W = 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        inv_i = 1'b0;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;

    inst_fetch_resp #(.IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .pc_i       (pc_i),
        .inv_i      (inv_i),
        .inst_o     (inst_o),
        .stallreq_o (stallreq_o),
        .bus_req_o  (bus_req_o),
        .bus_addr_o (bus_addr_o),
        .bus_ack_i  (bus_ack_i),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: buffered words keyed by word address, plus the one outstanding fetch.
    logic [31:0] cache [logic [31:0]];
    bit          m_busy = 1'b0;
    logic [31:0] m_addr = '0;

    // Last sampled outputs, for directed checks against constants.
    logic        s_stall;
    logic        s_req;
    logic [31:0] s_inst;
    logic [31:0] s_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned slot_of(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] victims[$];
        foreach (cache[k]) begin
            if (slot_of(k) == slot_of(a)) victims.push_back(k);
        end
        foreach (victims[i]) cache.delete(victims[i]);
        cache[a] = d;
    endtask

    task automatic model_reset();
        cache.delete();
        m_busy = 1'b0;
        m_addr = '0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic ce, input logic [31:0] pc, input logic inv,
                        input logic ack, input logic [31:0] rdata);
        logic [31:0] wa;
        logic        hit;
        logic        e_stall;
        logic [31:0] e_inst;
        @(negedge clk);
        ce_i        = ce;
        pc_i        = pc;
        inv_i       = inv;
        bus_ack_i   = ack;
        bus_rdata_i = rdata;
        #1;
        wa      = {pc[31:2], 2'b00};
        hit     = ce && cache.exists(wa);
        e_stall = ce && (m_busy || !hit);
        e_inst  = '0;
        if (ce && !m_busy && hit) e_inst = cache[wa];
        s_stall = stallreq_o;
        s_req   = bus_req_o;
        s_inst  = inst_o;
        s_addr  = bus_addr_o;
        check("stallreq", {31'b0, stallreq_o}, {31'b0, e_stall});
        check("inst", inst_o, e_inst);
        check("bus_req", {31'b0, bus_req_o}, {31'b0, m_busy});
        check("bus_addr", bus_addr_o, m_addr);
        if (m_busy) begin
            if (ack) begin
                model_fill(m_addr, rdata);
                m_busy = 1'b0;
            end
        end else if (ce && !hit) begin
            m_busy = 1'b1;
            m_addr = wa;
        end
        if (inv) cache.delete();
    endtask

    initial begin
        int stalls;
        logic        r_ce;
        logic [31:0] r_pc;

        model_reset();
        repeat (2) @(posedge clk);
        #3;
        ce_i = 1'b1;
        #1;
        check("reset_stall_follows_ce", {31'b0, stallreq_o}, 32'd1);
        check("reset_bus_req", {31'b0, bus_req_o}, 32'd0);
        ce_i = 1'b0;
        #2;
        rst = 1'b1;

        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("idle_no_ce_inst", s_inst, 32'h0);

        // Cold miss at 0x0, ack in cycle 1.
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        check("cold_c0_stall", {31'b0, s_stall}, 32'd1);
        step(1'b1, 32'h0, 1'b0, 1'b1, 32'h3C010101);
        check("cold_c1_stall", {31'b0, s_stall}, 32'd1);
        check("cold_c1_req", {31'b0, s_req}, 32'd1);
        check("cold_c1_addr", s_addr, 32'h0);
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        check("cold_c2_inst", s_inst, 32'h3C010101);
        check("cold_c2_stall", {31'b0, s_stall}, 32'd0);

        // Fill 0x4, then return to 0x0 as a hit.
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 1'b1, 32'h34210020);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        check("fill4_inst", s_inst, 32'h34210020);
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rehit0_inst", s_inst, 32'h3C010101);
        check("rehit0_req", {31'b0, s_req}, 32'd0);

        // Conflict at 0x10 with three request cycles before release.
        stalls = 0;
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        if (s_stall) stalls++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h10, 1'b0, (i == 2), 32'h12345678);
            if (s_stall) stalls++;
            check("conflict_addr", s_addr, 32'h10);
        end
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        if (s_stall) stalls++;
        check("conflict_stall_cycles", stalls, 32'd4);
        check("conflict_inst", s_inst, 32'h12345678);
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        check("conflict_evicted_0", {31'b0, s_stall}, 32'd1);
        step(1'b1, 32'h0, 1'b0, 1'b1, 32'h3C010101);
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);

        // ce_i drops while the fetch of 0x8 is outstanding.
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h8, 1'b0, 1'b0, 32'h0);
        check("ce_drop_stall", {31'b0, s_stall}, 32'd0);
        check("ce_drop_req", {31'b0, s_req}, 32'd1);
        step(1'b0, 32'h8, 1'b0, 1'b1, 32'hDEADBEEF);
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        check("ce_drop_hit", s_inst, 32'hDEADBEEF);
        check("ce_drop_hit_stall", {31'b0, s_stall}, 32'd0);

        // Invalidate on the same edge as the ack for 0x4 (0x4 evicted by 0x14 first).
        step(1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h14, 1'b0, 1'b1, 32'hCAFE0014);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h4, 1'b1, 1'b1, 32'h34210020);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        check("inv_refetch_stall", {31'b0, s_stall}, 32'd1);
        step(1'b1, 32'h4, 1'b0, 1'b1, 32'h34210020);
        check("inv_refetch_req", {31'b0, s_req}, 32'd1);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        check("inv_old_entry_miss", {31'b0, s_stall}, 32'd1);
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);

        // Async reset between edges while BUSY.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req", {31'b0, bus_req_o}, 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        check("post_rst_miss", {31'b0, s_stall}, 32'd1);
        step(1'b1, 32'h4, 1'b0, 1'b1, 32'h34210020);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);

        // Randomized traffic; PC is held while a fetch stalls, as ctrl would.
        r_ce = 1'b1;
        r_pc = 32'h4;
        for (int c = 0; c < 3000; c++) begin
            if (!(s_stall && r_ce)) begin
                r_ce = ($urandom_range(0, 99) < 85);
                r_pc = ({$urandom_range(0, 2)} << 20) | ({$urandom_range(0, 15)} << 2)
                       | {$urandom_range(0, 3)};
            end
            step(r_ce, r_pc, ($urandom_range(0, 19) == 0),
                 m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
                 $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Instruction-fetch responder at the far end of the PC/chip-enable fetch interface. It accepts `pc_i`/`ce_i`, answers hits from a small direct-mapped instruction buffer in the same cycle, and fetches misses from an external instruction bus with a req/ack handshake. While a miss is outstanding it raises `stallreq_o` to the pipeline ctrl block, which holds the PC stable until the instruction is returned.

## Interface
- `IDX_W`, default 2: buffer index width; the buffer has 2^IDX_W entries of one 32-bit word each.
- `clk  input  1  clock; all state updates on the rising edge`
- `rst  input  1  asynchronous, active-low reset`
- `ce_i  input  1  fetch enable from the PC register; 0 = no fetch`
- `pc_i  input  32  fetch address (byte address, word-aligned use)`
- `inv_i  input  1  invalidate all buffer entries (sampled on clk)`
- `inst_o  output  32  instruction for IF/ID; valid when ce_i=1 and stallreq_o=0`
- `stallreq_o  output  1  stall request to ctrl while a fetch is unresolved`
- `bus_req_o  output  1  instruction-bus read request (registered)`
- `bus_addr_o  output  32  instruction-bus word address (registered)`
- `bus_ack_i  input  1  bus read complete; rdata valid this cycle`
- `bus_rdata_i  input  32  bus read data`

## Operation
- Address split: index = `pc_i[IDX_W+1:2]`, tag = `pc_i[31:IDX_W+2]`; `pc_i[1:0]` is ignored. Each entry has valid, tag and data.
- Hit (combinational): `ce_i`=1, entry valid, tag equal -> `inst_o` = entry data, `stallreq_o`=0.
- `ce_i`=0 -> `inst_o`=0, `stallreq_o`=0, no new request started.
- Miss (`ce_i`=1, not hit) -> `inst_o`=0, `stallreq_o`=1 combinationally in the same cycle.
- FSM states: IDLE, BUSY.
  - IDLE + miss: at the edge, `bus_addr_o` <= `{pc_i[31:2],2'b00}`, `bus_req_o` <= 1, go to BUSY.
  - BUSY: `bus_req_o` and `bus_addr_o` are held stable. When `bus_ack_i`=1 is sampled, write `bus_rdata_i` into the entry indexed by `bus_addr_o`, set its tag and valid, `bus_req_o` <= 0, go to IDLE.
  - BUSY with `ce_i`=1: `stallreq_o`=1 regardless of hit, because the PC is frozen and the data is not yet buffered.
  - BUSY with `ce_i`=0: the transaction is never aborted. It runs to ack and fills the buffer. `stallreq_o`=0.
- `bus_ack_i` is ignored when `bus_req_o`=0.
- `inv_i`=1 clears every valid bit at the edge. This takes priority over a fill on the same edge, so the filled entry ends up invalid and the next lookup misses and refetches. `inv_i` does not cancel an outstanding request.
- A fill overwrites whatever entry shares the index (direct-mapped, no replacement policy).

## Timing
- Reset (rst=0, async): all valid=0, state IDLE, `bus_req_o`=0, `bus_addr_o`=0. Tags and data are don't-care. Combinational outputs follow from this: `inst_o`=0, and `stallreq_o`=`ce_i`.
- Reset asserted mid-BUSY: the request drops immediately and the fill is lost. The bus side tolerates this.
- Hit latency: 0 cycles (same-cycle `inst_o`).
- Miss sequence, with N = cycles `bus_req_o` is high before ack (N≥1):
  - Cycle 0: miss detected, stall.
  - Cycles 1..N: request outstanding.
  - Cycle N: ack sampled at the end of the cycle.
  - Cycle N+1: hit, stall released.
  - Total stall cycles = N+1; minimum 2.
- One outstanding request maximum; no new request is issued in the cycle the ack is captured.

## Test plan
- Cold miss: reset, `ce_i`=1, `pc_i`=0x00000000, ack in cycle 1 with rdata=0x3C010101. Required: `stallreq_o`=1 in cycles 0–1, `bus_req_o`=1/`bus_addr_o`=0x0 in cycle 1, then `inst_o`=0x3C010101 and `stallreq_o`=0 in cycle 2.
- Hit after fill: `pc_i` advances 0x0 -> 0x4 (fill 0x34210020) -> back to 0x0. Required: returning to 0x0 gives `inst_o`=0x3C010101 with no stall and no `bus_req_o`.
- Conflict and wait states (IDX_W=2): fill 0x00, then `pc_i`=0x10, acked after 3 wait cycles. Required: 4 stall cycles, `bus_addr_o`=0x10 stable throughout; a following access to 0x00 misses again.
- `ce_i` drop mid-miss: `ce_i` 1->0 in BUSY, ack two cycles later with 0xDEADBEEF at 0x8. Required: `stallreq_o`=0 while `ce_i`=0, fill completes; with `ce_i`=1 at `pc_i`=0x8, `inst_o`=0xDEADBEEF with no stall.
- Invalidate: `inv_i` pulses on the same edge as ack for 0x4. Required: next cycle 0x4 misses, `stallreq_o`=1, a new `bus_req_o` is issued; earlier entries also miss.
- Async reset mid-BUSY: rst=0 between edges. Required: `bus_req_o`=0 immediately; after release, the previously filled address misses.
